spi_cmd_controller: RTL

//  SPI mode-0 controller (initiator) that drives the onboarding SPI peripheral's SCLK/COPI/nCS pins.

---
 rtl/spi_ctrl_pkg.sv | 30 +++
 rtl/spi_halfper_tick.sv | 47 ++++
 rtl/spi_cmd_controller.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI command controller.
//   FRAME_W      : serial frame length, {rw, addr[6:0], data[7:0]}
//   RW_WRITE/READ: values of frame bit 15
//   spi_ctrl_state_t : controller FSM states
//   pack_frame() : assemble the 16-bit frame from request fields
package spi_ctrl_pkg;

    localparam int unsigned FRAME_W      = 16;
    localparam int unsigned FRAME_ADDR_W = 7;
    localparam int unsigned FRAME_DATA_W = 8;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP
    } spi_ctrl_state_t;

    function automatic logic [FRAME_W-1:0] pack_frame(
        input logic                    rw,
        input logic [FRAME_ADDR_W-1:0] addr,
        input logic [FRAME_DATA_W-1:0] data
    );
        return {rw, addr, data};
    endfunction

endpackage

// File: rtl/spi_halfper_tick.sv
// SCLK half-period timer for the SPI command controller.
// Counts 0..CLK_DIV-1 while enabled and wraps; the count is forced to zero
// by reset or by clear_i.
//   clk        : system clock
//   rst_n      : synchronous active-low reset
//   clear_i    : restart the half-period (request handshake)
//   en_i       : count enable (controller busy)
//   tick_o     : last cycle of a half-period (count == CLK_DIV-1)
//   pre_tick_o : second-to-last cycle of a half-period (count == CLK_DIV-2)
module spi_halfper_tick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic tick_o,
    output logic pre_tick_o
);

    localparam int unsigned CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(CLK_DIV - 2);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o     = en_i && (cnt_q == CNT_LAST);
    assign pre_tick_o = en_i && (cnt_q == CNT_PRE);

endmodule

// File: rtl/spi_cmd_controller.sv
// SPI mode-0 initiator: serialises one 16-bit command {rw, addr, data}
// MSB first per accepted request, driving SCLK/COPI/nCS.
//   clk, rst_n            : clock, synchronous active-low reset
//   req_valid/req_ready   : request handshake (ready iff FSM idle)
//   req_rw/addr/data      : command fields, captured at the handshake
//   sclk, copi, ncs       : SPI pins (sclk idles low, ncs active low)
//   busy                  : FSM not idle
//   done                  : one-cycle pulse in the last GAP cycle
// Optional SPI_CMD_CTRL_READBACK_EN adds:
//   cipo                  : serial data from the peripheral
//   rsp_data              : last 8 bits sampled in a read frame
module spi_cmd_controller
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              sclk,
    output logic              copi,
    output logic              ncs,
    output logic              busy,
`ifdef SPI_CMD_CTRL_READBACK_EN
    input  logic              cipo,
    output logic [DATA_W-1:0] rsp_data,
`endif
    output logic              done
);

    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("spi_cmd_controller: CLK_DIV must be >= 2");
    end
    if (ADDR_W != FRAME_ADDR_W || DATA_W != FRAME_DATA_W) begin : g_bad_widths
        $error("spi_cmd_controller: ADDR_W/DATA_W are fixed by the frame format");
    end

    localparam logic [3:0] LAST_BIT = 4'(FRAME_W - 1);

    spi_ctrl_state_t    state_q, state_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic               last_q, last_d;
    logic               ncs_q, ncs_d;
    logic               sclk_q, sclk_d;
    logic               copi_q, copi_d;
    logic               done_q, done_d;

    logic               handshake;
    logic               tick;
    logic               pre_tick;
    logic [FRAME_W-1:0] frame_in;

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign handshake = req_valid && req_ready;
    assign frame_in  = pack_frame(req_rw, req_addr, req_data);

    spi_halfper_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (handshake),
        .en_i       (busy),
        .tick_o     (tick),
        .pre_tick_o (pre_tick)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        last_d    = last_q;
        ncs_d     = ncs_q;
        sclk_d    = sclk_q;
        copi_d    = copi_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (handshake) begin
                    shreg_d   = frame_in;
                    bit_cnt_d = '0;
                    last_d    = 1'b0;
                    ncs_d     = 1'b0;
                    sclk_d    = 1'b0;
                    copi_d    = frame_in[FRAME_W-1];
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                // First rising SCLK edge of the frame.
                if (tick) begin
                    sclk_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        // After bit 0 copi stays put; last_q marks the hold phase.
                        if (bit_cnt_q == LAST_BIT) begin
                            last_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                            copi_d    = shreg_q[FRAME_W-2];
                            shreg_d   = {shreg_q[FRAME_W-2:0], 1'b0};
                        end
                    end else if (last_q) begin
                        ncs_d   = 1'b1;
                        copi_d  = 1'b0;
                        state_d = GAP;
                    end else begin
                        sclk_d = 1'b1;
                    end
                end
            end
            GAP: begin
                // Registered one cycle early so the pulse lands on the last GAP cycle.
                done_d = pre_tick;
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            last_q    <= 1'b0;
            ncs_q     <= 1'b1;
            sclk_q    <= 1'b0;
            copi_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            last_q    <= last_d;
            ncs_q     <= ncs_d;
            sclk_q    <= sclk_d;
            copi_q    <= copi_d;
            done_q    <= done_d;
        end
    end

    assign ncs  = ncs_q;
    assign sclk = sclk_q;
    assign copi = copi_q;
    assign done = done_q;

`ifdef SPI_CMD_CTRL_READBACK_EN
    logic              rw_q;
    logic [DATA_W-1:0] rx_q;
    logic [DATA_W-1:0] rsp_q;
    logic              sample;

    // cipo is captured on the same edge that drives sclk 0->1.
    assign sample = tick && !sclk_q &&
                    ((state_q == SETUP) || (state_q == SHIFT && !last_q));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rw_q  <= 1'b0;
            rx_q  <= '0;
            rsp_q <= '0;
        end else begin
            if (handshake) begin
                rw_q <= req_rw;
            end
            if (sample) begin
                rx_q <= {rx_q[DATA_W-2:0], cipo};
            end
            if (done_d && rw_q == RW_READ) begin
                rsp_q <= rx_q;
            end
        end
    end

    assign rsp_data = rsp_q;
`endif

endmodule
